branch_resolve_unit: RTL and testbench

//  Pipelined, parametrised branch resolution stage for the RV32/RV64 core. Evaluates the six

---
 rtl/br_pkg.sv | 37 +++
 rtl/br_sat_counter.sv | 25 ++
 rtl/branch_resolve_unit.sv | 152 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared branch-compare encodings and the condition evaluator used by the
// branch resolve pipeline.
package br_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b010;
    localparam logic [2:0] CMP_BGE  = 3'b011;
    localparam logic [2:0] CMP_BLTU = 3'b100;
    localparam logic [2:0] CMP_BGEU = 3'b101;

    function automatic logic br_is_illegal(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

    // Operands arrive sign-extended to MAX_XLEN; sign extension preserves both the
    // signed and the unsigned ordering of the original XLEN-bit values.
    function automatic logic br_cond_eval(input logic [2:0]                 op,
                                          input logic signed [MAX_XLEN-1:0] a,
                                          input logic signed [MAX_XLEN-1:0] b);
        logic r;
        r = 1'b0;
        case (op)
            CMP_BEQ:  r = (a == b);
            CMP_BNE:  r = (a != b);
            CMP_BLT:  r = (a < b);
            CMP_BGE:  r = (a >= b);
            CMP_BLTU: r = ($unsigned(a) < $unsigned(b));
            CMP_BGEU: r = ($unsigned(a) >= $unsigned(b));
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/br_sat_counter.sv
// Saturating event counter; sticks at all-ones.
module br_sat_counter
    import br_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined RISC-V branch resolution: condition evaluation, next-PC computation,
// mispredict detection, valid/ready flow control and retire counters.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_a,
    input  logic [XLEN-1:0]  i_b,
    input  logic [2:0]       i_cmp_op,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_pred_target,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken,
    output logic [XLEN-1:0]  o_next_pc,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mp_cnt
);

    // Stage 0: condition evaluation on the incoming beat
    logic signed [XLEN-1:0]     a_s, b_s;
    logic signed [MAX_XLEN-1:0] a_x, b_x;
    logic                       taken_p0, illegal_p0;

    assign a_s        = i_a;
    assign b_s        = i_b;
    assign a_x        = MAX_XLEN'(a_s);
    assign b_x        = MAX_XLEN'(b_s);
    assign illegal_p0 = br_is_illegal(i_cmp_op);
    assign taken_p0   = !illegal_p0 && br_cond_eval(i_cmp_op, a_x, b_x);

    // Signals feeding the final (output) stage, sourced per pipeline depth
    logic            vld_ck, taken_ck, illegal_ck, pt_ck;
    logic [XLEN-1:0] pc_ck, imm_ck, ptgt_ck;
    logic            vld_pn, ready_pn;

    assign ready_pn = !vld_pn || i_ready;

    generate
        if (STAGES == 1) begin : g_one
            assign vld_ck     = i_valid;
            assign taken_ck   = taken_p0;
            assign illegal_ck = illegal_p0;
            assign pc_ck      = i_pc;
            assign imm_ck     = i_imm;
            assign pt_ck      = i_pred_taken;
            assign ptgt_ck    = i_pred_target;
            assign o_ready    = ready_pn;
        end else begin : g_two
            // Stage 1 boundary: compare result registered with the operands for target/check
            logic            vld_p1, taken_p1, illegal_p1, pt_p1;
            logic [XLEN-1:0] pc_p1, imm_p1, ptgt_p1;
            logic            ready_p1;

            assign ready_p1 = !vld_p1 || ready_pn;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                end else if (i_flush) begin
                    vld_p1 <= 1'b0;
                end else if (ready_p1) begin
                    vld_p1 <= i_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (ready_p1 && i_valid && !i_flush) begin
                    taken_p1   <= taken_p0;
                    illegal_p1 <= illegal_p0;
                    pc_p1      <= i_pc;
                    imm_p1     <= i_imm;
                    pt_p1      <= i_pred_taken;
                    ptgt_p1    <= i_pred_target;
                end
            end

            assign vld_ck     = vld_p1;
            assign taken_ck   = taken_p1;
            assign illegal_ck = illegal_p1;
            assign pc_ck      = pc_p1;
            assign imm_ck     = imm_p1;
            assign pt_ck      = pt_p1;
            assign ptgt_ck    = ptgt_p1;
            assign o_ready    = ready_p1;
        end
    endgenerate

    // Target and prediction check; illegal ops never redirect
    logic [XLEN-1:0] next_pc_ck;
    logic            mp_ck;

    assign next_pc_ck = taken_ck ? (pc_ck + imm_ck) : (pc_ck + XLEN'(4));
    assign mp_ck      = !illegal_ck &&
                        ((taken_ck != pt_ck) || (taken_ck && (next_pc_ck != ptgt_ck)));

    // Output stage boundary: result register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pn       <= 1'b0;
            o_taken      <= 1'b0;
            o_next_pc    <= '0;
            o_mispredict <= 1'b0;
            o_illegal    <= 1'b0;
        end else begin
            if (i_flush) begin
                vld_pn <= 1'b0;
            end else if (ready_pn) begin
                vld_pn <= vld_ck;
            end
            if (!i_flush && ready_pn && vld_ck) begin
                o_taken      <= taken_ck;
                o_next_pc    <= next_pc_ck;
                o_mispredict <= mp_ck;
                o_illegal    <= illegal_ck;
            end
        end
    end

    assign o_valid = vld_pn;

    logic retire, retire_mp;
    assign retire    = vld_pn && i_ready && !o_illegal;
    assign retire_mp = retire && o_mispredict;

    br_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .cnt   (o_br_cnt)
    );

    br_sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire_mp),
        .cnt   (o_mp_cnt)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a queue-based
// behavioural model of in-flight beats.
module tb_branch_resolve_unit;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk, rst_n, i_flush, i_valid, o_ready, i_ready;
    logic [XLEN-1:0]  i_a, i_b, i_pc, i_imm, i_pred_target, o_next_pc;
    logic [2:0]       i_cmp_op;
    logic             i_pred_taken, o_valid, o_taken, o_mispredict, o_illegal;
    logic [CNT_W-1:0] o_br_cnt, o_mp_cnt;

    branch_resolve_unit #(.XLEN(XLEN), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_cmp_op      (i_cmp_op),
        .i_pc          (i_pc),
        .i_imm         (i_imm),
        .i_pred_taken  (i_pred_taken),
        .i_pred_target (i_pred_target),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_taken       (o_taken),
        .o_next_pc     (o_next_pc),
        .o_mispredict  (o_mispredict),
        .o_illegal     (o_illegal),
        .o_br_cnt      (o_br_cnt),
        .o_mp_cnt      (o_mp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              c;
        logic            t;
        logic [XLEN-1:0] np;
        logic            mp;
        logic            ill;
    } exp_t;

    exp_t q[$];
    int   cyc, errors, checks, br_m, mp_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of a branch, straight from the RISC-V rules
    function automatic exp_t ref_model(input logic [2:0] op, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                       input logic [XLEN-1:0] imm, input logic pt,
                                       input logic [XLEN-1:0] ptgt);
        exp_t e;
        e.c   = 0;
        e.ill = (op == 3'd6) || (op == 3'd7);
        case (op)
            3'd0:    e.t = (a == b);
            3'd1:    e.t = (a != b);
            3'd2:    e.t = ($signed(a) <  $signed(b));
            3'd3:    e.t = ($signed(a) >= $signed(b));
            3'd4:    e.t = (a <  b);
            3'd5:    e.t = (a >= b);
            default: e.t = 1'b0;
        endcase
        e.np = e.t ? pc + imm : pc + 32'd4;
        e.mp = e.ill ? 1'b0 : ((e.t != pt) || (e.t && e.np != ptgt));
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input logic pt,
                         input logic [XLEN-1:0] ptgt);
        i_valid = v; i_cmp_op = op; i_a = a; i_b = b; i_pc = pc; i_imm = imm;
        i_pred_taken = pt; i_pred_target = ptgt;
    endtask

    task automatic rand_beat(input logic v);
        logic [XLEN-1:0] a, b, pc, imm, ptgt;
        logic [XLEN-1:0] corners [4];
        corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;
        a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom);
        pc  = {$urandom, 2'b00} ;
        imm = {{20{1'b0}}, 12'($urandom)} - 32'h800;
        ptgt = $urandom_range(0, 1) ? pc + imm : $urandom;
        drive(v, 3'($urandom_range(0, 7)), a, b, pc, imm, 1'($urandom_range(0, 1)), ptgt);
    endtask

    // One clock: checks taken just before the edge, counters just after
    task automatic tick();
        exp_t e;
        logic exp_rdy, exp_ov, out_hs, in_hs;
        int   n;
        #1;
        n       = q.size();
        exp_rdy = (n < STAGES) || i_ready;
        exp_ov  = (n > 0) && (cyc >= q[0].c + STAGES);
        chk("o_ready", 64'(o_ready), 64'(exp_rdy));
        chk("o_valid", 64'(o_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("o_taken",      64'(o_taken),      64'(q[0].t));
            chk("o_next_pc",    64'(o_next_pc),    64'(q[0].np));
            chk("o_mispredict", 64'(o_mispredict), 64'(q[0].mp));
            chk("o_illegal",    64'(o_illegal),    64'(q[0].ill));
        end
        out_hs = exp_ov && i_ready;
        in_hs  = i_valid && exp_rdy && !i_flush;
        if (out_hs) begin
            if (!q[0].ill) begin
                if (br_m < CMAX) br_m++;
                if (q[0].mp && mp_m < CMAX) mp_m++;
            end
            void'(q.pop_front());
        end
        if (i_flush) q.delete();
        if (in_hs) begin
            e   = ref_model(i_cmp_op, i_a, i_b, i_pc, i_imm, i_pred_taken, i_pred_target);
            e.c = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("o_br_cnt", 64'(o_br_cnt), 64'(br_m));
        chk("o_mp_cnt", 64'(o_mp_cnt), 64'(mp_m));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   64'(o_valid),      64'd0);
        chk({tag, "_taken"},   64'(o_taken),      64'd0);
        chk({tag, "_next_pc"}, 64'(o_next_pc),    64'd0);
        chk({tag, "_mp"},      64'(o_mispredict), 64'd0);
        chk({tag, "_illegal"}, 64'(o_illegal),    64'd0);
        chk({tag, "_br_cnt"},  64'(o_br_cnt),     64'd0);
        chk({tag, "_mp_cnt"},  64'(o_mp_cnt),     64'd0);
        chk({tag, "_ready"},   64'(o_ready),      64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        br_m = 0;
        mp_m = 0;
    endtask

    int br_save, mp_save;

    initial begin
        errors = 0; checks = 0; cyc = 0; br_m = 0; mp_m = 0;
        rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // beq taken, predicted not-taken
        drive(1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        tick(); tick();
        chk("t1_mp_cnt", 64'(o_mp_cnt), 64'd1);
        chk("t1_br_cnt", 64'(o_br_cnt), 64'd1);

        // signed / unsigned compare corners
        drive(1'b1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210); tick();
        drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h10, 1'b0, 32'h0);   tick();
        drive(1'b1, 3'd3, 32'h8000_0000, 32'd0, 32'h208, 32'h10, 1'b0, 32'h0);   tick();
        // PC wrap-around, taken and not-taken
        drive(1'b1, 3'd1, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'd4);      tick();
        drive(1'b1, 3'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'd0);      tick();
        // illegal op with a misleading prediction
        drive(1'b1, 3'd7, 32'd3, 32'd3, 32'h300, 32'h40, 1'b1, 32'h340);         tick();
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (3) tick();

        // 8 back-to-back beats, then a 3-cycle consumer stall while feeding
        for (int i = 0; i < 8; i++) begin rand_beat(1'b1); tick(); end
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_beat(1'b1); tick(); end
        i_ready = 1'b1;
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (4) tick();

        // flush with two beats in flight, a beat offered in the flush cycle
        br_save = br_m; mp_save = mp_m;
        i_ready = 1'b0;
        rand_beat(1'b1); tick();
        rand_beat(1'b1); tick();
        i_flush = 1'b1; rand_beat(1'b1); tick();
        i_flush = 1'b0; drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        tick();
        chk("flush_valid",  64'(o_valid),  64'd0);
        chk("flush_br_cnt", 64'(o_br_cnt), 64'(br_save));
        chk("flush_mp_cnt", 64'(o_mp_cnt), 64'(mp_save));
        i_ready = 1'b1;
        // flush coinciding with an output handshake
        rand_beat(1'b1); tick();
        rand_beat(1'b1); tick();
        i_flush = 1'b1; drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0); tick();
        i_flush = 1'b0; repeat (2) tick();

        // randomized traffic with backpressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            rand_beat(1'($urandom_range(0, 3) != 0));
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        i_flush = 1'b0; i_ready = 1'b1;
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (4) tick();

        // counter saturation with 20 mispredicted branches
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'd0, 32'd9, 32'd9, 32'h400 + 32'(i * 4), 32'h80, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (3) tick();
        chk("sat_br_cnt", 64'(o_br_cnt), 64'(CMAX));
        chk("sat_mp_cnt", 64'(o_mp_cnt), 64'(CMAX));

        // asynchronous reset with beats in flight
        i_ready = 1'b0;
        rand_beat(1'b1); tick();
        drive(1'b1, 3'd1, 32'd1, 32'd2, 32'h500, 32'h44, 1'b1, 32'h544); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); br_m = 0; mp_m = 0;
        i_ready = 1'b1;
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (3) tick();
        rand_beat(1'b1); tick();
        drive(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
